// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg
//  Brief    : Shared mode encodings, datapath widths and latency for the
//             convolution ALU pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

   // Output conditioning modes; code 3 is reserved and treated as saturate.
   localparam logic [1:0] c_mode_wrap    = 2'd0;
   localparam logic [1:0] c_mode_sat     = 2'd1;
   localparam logic [1:0] c_mode_abs_sat = 2'd2;

   // Beats emerge this many advancing cycles after acceptance.
   localparam int c_latency = 3;

   // Signed product of a zero-extended pixel and a signed coefficient.
   function automatic int prod_w(input int cw, input int kw);
      return cw + kw + 1;
   endfunction

   // Accumulator wide enough that summing every tap can never overflow.
   function automatic int sum_w(input int cw, input int kw, input int taps);
      return cw + kw + 1 + $clog2(taps);
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_alu_lane.sv
`default_nettype none
// ============================================================================
//  Module   : conv_alu_lane
//  Brief    : One colour channel: per-tap products (S1), tap sum (S2), then
//             combinational shift-divide and wrap/saturate conditioning.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_alu_lane
   import conv_pkg::*;
#(
   parameter int TAPS = 9,
   parameter int CW   = 4,
   parameter int KW   = 5,
   parameter int DIVW = 3
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic [TAPS*CW-1:0]   pix,
   input  logic [TAPS*KW-1:0]   kernel,
   input  logic [DIVW-1:0]      div_s2,
   input  logic [1:0]           mode_s2,
   output logic [CW-1:0]        res
);

   localparam int c_pw = prod_w(CW, KW);
   localparam int c_sw = sum_w(CW, KW, TAPS);
   localparam logic signed [c_sw-1:0] c_max = c_sw'((1 << CW) - 1);

   logic signed [c_pw-1:0] w_pix_ext  [TAPS];
   logic signed [c_pw-1:0] w_coef_ext [TAPS];
   logic signed [c_pw-1:0] r_prod     [TAPS];
   logic signed [c_sw-1:0] w_sum;
   logic signed [c_sw-1:0] r_sum;
   logic signed [c_sw-1:0] w_shift;
   logic signed [c_sw-1:0] w_sel;

   // Both operands are brought to full product width so the multiply is exact.
   generate
      for (genvar t = 0; t < TAPS; t++) begin : g_tap
         assign w_pix_ext[t]  = {{(KW+1){1'b0}}, pix[t*CW +: CW]};
         assign w_coef_ext[t] = {{(CW+1){kernel[t*KW+KW-1]}}, kernel[t*KW +: KW]};
      end
   endgenerate

   // S1: register every tap product.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int t = 0; t < TAPS; t++) begin
            r_prod[t] <= w_pix_ext[t] * w_coef_ext[t];
         end
      end
   end

   // Sign-extend each product into the accumulator and add them up.
   always_comb begin
      w_sum = '0;
      for (int t = 0; t < TAPS; t++) begin
         w_sum = w_sum + {{(c_sw-c_pw){r_prod[t][c_pw-1]}}, r_prod[t]};
      end
   end

   // S2: register the channel sum.
   always_ff @(posedge clk) begin
      if (en) begin
         r_sum <= w_sum;
      end
   end

   // Arithmetic shift floors toward minus infinity; ABS_SAT folds the sign first.
   always_comb begin
      w_shift = r_sum >>> div_s2;
      w_sel   = (mode_s2 == c_mode_abs_sat && w_shift[c_sw-1]) ? -w_shift : w_shift;
      res     = w_shift[CW-1:0];
      if (mode_s2 != c_mode_wrap) begin
         if (w_sel[c_sw-1]) begin
            res = '0;
         end else if (w_sel > c_max) begin
            res = '1;
         end else begin
            res = w_sel[CW-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : conv_alu_pipe
//  Brief    : Three-stage convolution ALU with valid/ready handshake; one
//             conv_alu_lane per colour channel, per-beat divide and mode.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_alu_pipe
   import conv_pkg::*;
#(
   parameter int TAPS = 9,
   parameter int NCH  = 3,
   parameter int CW   = 4,
   parameter int KW   = 5,
   parameter int DIVW = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [TAPS*NCH*CW-1:0]  in_pix,
   input  logic [TAPS*KW-1:0]      in_kernel,
   input  logic [DIVW-1:0]         in_div,
   input  logic [1:0]              in_mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NCH*CW-1:0]       out_pix
);

   logic                w_en;
   logic                r_v1;
   logic                r_v2;
   logic                r_out_valid;
   logic [NCH*CW-1:0]   r_out_pix;
   logic [DIVW-1:0]     r_div1;
   logic [DIVW-1:0]     r_div2;
   logic [1:0]          r_mode1;
   logic [1:0]          r_mode2;
   logic [NCH*CW-1:0]   w_res;

   // The whole pipe moves together whenever the output slot is free or draining.
   assign w_en      = !r_out_valid || out_ready;
   assign in_ready  = w_en || !rst_n;
   assign out_valid = r_out_valid;
   assign out_pix   = r_out_pix;

   // Valid bits and the output register; reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_pix   <= '0;
      end else if (w_en) begin
         r_v1        <= in_valid;
         r_v2        <= r_v1;
         r_out_valid <= r_v2;
         r_out_pix   <= w_res;
      end
   end

   // Divide and mode travel with their beat so settings can change per beat.
   always_ff @(posedge clk) begin
      if (w_en) begin
         r_div1  <= in_div;
         r_mode1 <= in_mode;
         r_div2  <= r_div1;
         r_mode2 <= r_mode1;
      end
   end

   generate
      for (genvar c = 0; c < NCH; c++) begin : g_lane
         logic [TAPS*CW-1:0] w_lane_pix;

         for (genvar t = 0; t < TAPS; t++) begin : g_tap
            assign w_lane_pix[t*CW +: CW] = in_pix[(t*NCH+c)*CW +: CW];
         end

         conv_alu_lane #(
            .TAPS (TAPS),
            .CW   (CW),
            .KW   (KW),
            .DIVW (DIVW)
         ) u_lane (
            .clk     (clk),
            .en      (w_en),
            .pix     (w_lane_pix),
            .kernel  (in_kernel),
            .div_s2  (r_div2),
            .mode_s2 (r_mode2),
            .res     (w_res[c*CW +: CW])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_conv_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_alu_pipe
//  Brief    : Self-checking bench for conv_alu_pipe: directed corner cases
//             plus randomized traffic against a plain-arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_alu_pipe;

   localparam int TAPS = 9;
   localparam int NCH  = 3;
   localparam int CW   = 4;
   localparam int KW   = 5;
   localparam int DIVW = 3;
   localparam int PXW  = TAPS*NCH*CW;
   localparam int KNW  = TAPS*KW;
   localparam int OW   = NCH*CW;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [PXW-1:0]  in_pix;
   logic [KNW-1:0]  in_kernel;
   logic [DIVW-1:0] in_div;
   logic [1:0]      in_mode;
   logic            out_valid;
   logic            out_ready;
   logic [OW-1:0]   out_pix;

   int n_tests = 0;
   int n_fail  = 0;
   int n_out   = 0;
   bit saw_stall = 0;
   bit prev_stall = 0;
   logic [OW-1:0] prev_pix;
   logic [OW-1:0] sb[$];

   conv_alu_pipe #(
      .TAPS (TAPS), .NCH (NCH), .CW (CW), .KW (KW), .DIVW (DIVW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pix    (in_pix),
      .in_kernel (in_kernel),
      .in_div    (in_div),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pix   (out_pix)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: integer convolution, floor division by 2^div, then conditioning.
   function automatic logic [OW-1:0] model(input logic [PXW-1:0] p, input logic [KNW-1:0] k,
                                           input int d, input int m);
      logic [OW-1:0] r;
      int sum, s, dv, kc, pv;
      r = '0;
      for (int c = 0; c < NCH; c++) begin
         sum = 0;
         for (int t = 0; t < TAPS; t++) begin
            pv  = int'(p[(t*NCH+c)*CW +: CW]);
            kc  = int'($signed(k[t*KW +: KW]));
            sum += pv * kc;
         end
         dv = 1 << d;
         if (sum >= 0) s = sum / dv;
         else          s = -((-sum + dv - 1) / dv);
         if (m == 0) begin
            r[c*CW +: CW] = s[CW-1:0];
         end else begin
            if (m == 2 && s < 0) s = -s;
            if (s < 0)                r[c*CW +: CW] = '0;
            else if (s > (1<<CW) - 1) r[c*CW +: CW] = '1;
            else                      r[c*CW +: CW] = s[CW-1:0];
         end
      end
      return r;
   endfunction

   function automatic logic [PXW-1:0] fill_pix(input logic [OW-1:0] px);
      logic [PXW-1:0] v;
      for (int t = 0; t < TAPS; t++) v[t*OW +: OW] = px;
      return v;
   endfunction

   function automatic logic [KNW-1:0] fill_kern(input logic [KW-1:0] kc);
      logic [KNW-1:0] v;
      for (int t = 0; t < TAPS; t++) v[t*KW +: KW] = kc;
      return v;
   endfunction

   // Scoreboard and stall monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_pix", {20'd0, out_pix}, {20'd0, prev_pix});
         end
         if (in_valid && in_ready)
            sb.push_back(model(in_pix, in_kernel, int'(in_div), int'(in_mode)));
         if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            else                chk("scoreboard", {20'd0, out_pix}, {20'd0, sb.pop_front()});
         end
         if (!in_ready) saw_stall = 1;
         prev_stall = out_valid && !out_ready;
         prev_pix   = out_pix;
      end
   end

   // Present one beat and hold it until it is accepted.
   task automatic send(input logic [PXW-1:0] p, input logic [KNW-1:0] k,
                       input logic [DIVW-1:0] d, input logic [1:0] m);
      int guard;
      bit acc;
      in_valid = 1'b1; in_pix = p; in_kernel = k; in_div = d; in_mode = m;
      guard = 0;
      do begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
         guard++;
      end while (!acc && guard < 50);
      if (!acc) chk("send_timeout", {31'd0, acc}, 32'd1);
      in_valid = 1'b0;
   endtask

   // Single beat into an empty pipe: check latency and an exact constant result.
   task automatic run_dir(input string tag, input logic [PXW-1:0] p, input logic [KNW-1:0] k,
                          input logic [DIVW-1:0] d, input logic [1:0] m, input logic [OW-1:0] exp);
      int lat;
      send(p, k, d, m);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, 32'd3);
      chk({tag, "_pix"}, {20'd0, out_pix}, {20'd0, exp});
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [PXW-1:0] p;
      logic [KNW-1:0] k;
      logic [OW-1:0]  got_a, got_b;
      int base, nseen, guard;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_pix = '0; in_kernel = '0; in_div = '0; in_mode = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_pix", {20'd0, out_pix}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Identity kernel.
      p = '0; p[4*OW +: OW] = 12'hABC;
      k = '0; k[4*KW +: KW] = 5'd1;
      run_dir("identity", p, k, 3'd0, 2'd0, 12'hABC);

      // Box blur: 9*15 = 135, >>3 = 16.
      run_dir("blur_sat", fill_pix(12'hFFF), fill_kern(5'd1), 3'd3, 2'd1, 12'hFFF);
      run_dir("blur_wrap", fill_pix(12'hFFF), fill_kern(5'd1), 3'd3, 2'd0, 12'h000);
      run_dir("blur_rsvd", fill_pix(12'hFFF), fill_kern(5'd1), 3'd3, 2'd3, 12'hFFF);

      // Negative result: centre -1 on 0x555 gives -5 per channel.
      p = '0; p[4*OW +: OW] = 12'h555;
      k = '0; k[4*KW +: KW] = 5'h1F;
      run_dir("neg_sat", p, k, 3'd0, 2'd1, 12'h000);
      run_dir("neg_abs", p, k, 3'd0, 2'd2, 12'h555);
      run_dir("neg_wrap", p, k, 3'd0, 2'd0, 12'hBBB);

      // Back-pressure: 5 beats while the sink stalls for 4 cycles.
      base = n_out; saw_stall = 0; out_ready = 1'b0;
      fork
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 5; i++)
               send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom},
                    3'($urandom), 2'($urandom));
         end
      join
      repeat (10) @(posedge clk);
      #1;
      chk("bp_count", n_out - base, 32'd5);
      chk("bp_stall_seen", {31'd0, saw_stall}, 32'd1);

      // Reset with two beats in flight.
      base = n_out;
      send(fill_pix(12'h321), fill_kern(5'd2), 3'd0, 2'd1);
      send(fill_pix(12'h111), fill_kern(5'd1), 3'd0, 2'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_no_emit", n_out - base, 32'd0);
      p = '0; p[4*OW +: OW] = 12'h7E2;
      k = '0; k[4*KW +: KW] = 5'd1;
      run_dir("post_rst", p, k, 3'd0, 2'd0, 12'h7E2);

      // Back-to-back beats with different divide/mode.
      p = '0; p[4*OW +: OW] = 12'h9C3;
      k = '0; k[4*KW +: KW] = 5'd1;
      send(p, k, 3'd0, 2'd0);
      send(fill_pix(12'h123), fill_kern(5'd1), 3'd2, 2'd1);
      nseen = 0; guard = 0; got_a = '0; got_b = '0;
      while (nseen < 2 && guard < 20) begin
         if (out_valid) begin
            if (nseen == 0) got_a = out_pix;
            else            got_b = out_pix;
            nseen++;
         end
         @(posedge clk); #1;
         guard++;
      end
      chk("permode_count", nseen, 32'd2);
      chk("permode_a", {20'd0, got_a}, 32'h9C3);
      chk("permode_b", {20'd0, got_b}, 32'h246);

      // Randomized traffic with random back-pressure.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom % 4) != 0;
         in_pix    = {$urandom, $urandom, $urandom, $urandom};
         in_kernel = {$urandom, $urandom};
         in_div    = 3'($urandom);
         in_mode   = 2'($urandom);
         out_ready = ($urandom % 4) != 0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("drain_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
